// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types for the pipeline hold/flush controller: FSM states and the per-stage
// control bundle with its canned patterns.
package pipe_hold_ctrl_pkg;

    localparam int unsigned PcWidth = 64;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHaz   = 2'd1,
        StFlush = 2'd2,
        StErr   = 2'd3
    } hold_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_en;
    } stage_ctrl_t;

    localparam stage_ctrl_t CtrlRun = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b1
    };
    // Hazard hold: freeze PC and IF/ID, inject a bubble into EX, let older work drain.
    localparam stage_ctrl_t CtrlHold = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b1
    };
    localparam stage_ctrl_t CtrlFlush = '{
        pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_en: 1'b1
    };
    localparam stage_ctrl_t CtrlOff = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0
    };

endpackage

// File: rtl/pipe_hold_ctrl_hold_watchdog.sv
// Counts consecutive hazard-hold cycles and flags the one that would reach MAX_HOLD.
module pipe_hold_ctrl_hold_watchdog #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        count_en,
    input  logic                        clear,
    input  logic                        freeze,
    output logic [$clog2(MAX_HOLD)-1:0] hold_cnt,
    output logic                        timeout
);
    localparam int unsigned CntW = $clog2(MAX_HOLD);

    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            last;

    assign last = (hold_cnt_q == CntW'(MAX_HOLD - 1));

    // Clear wins over freeze so a redirect taken under a memory stall still drops the hold.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (clear) begin
            hold_cnt_d = '0;
        end else if (count_en && !freeze && !last) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign hold_cnt = hold_cnt_q;
    assign timeout  = count_en & ~freeze & ~clear & last;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: hazard holds, branch redirect handshake, hold watchdog.
// Optional perf counters are built only when PIPE_HOLD_PERF_EN is defined.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = PcWidth,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_HOLD     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rest_from_id,
    input  logic            branch_flush,
    input  logic [PC_W-1:0] branch_target,
    input  logic            mem_busy,
    input  logic            redirect_ready,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_en,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            hang_err,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_events
);
    localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned HoldW  = $clog2(MAX_HOLD);

    hold_state_e       state_q, state_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic              hang_err_q, hang_err_d;
    logic              take_branch, hold_req, redirect_fire;
    logic              hold_count_en, hold_clear, timeout;
    logic [HoldW-1:0]  hold_cnt;
    logic              unused_hold_cnt;
    stage_ctrl_t       ctrl;

    assign take_branch   = branch_flush & (state_q != StErr);
    assign hold_req      = rest_from_id & ((state_q == StRun) | (state_q == StHaz));
    assign redirect_fire = redirect_valid_q & redirect_ready;
    assign hold_count_en = hold_req & ~take_branch;
    assign hold_clear    = take_branch | (~mem_busy & ~hold_req);

    pipe_hold_ctrl_hold_watchdog #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .count_en(hold_count_en),
        .clear   (hold_clear),
        .freeze  (mem_busy),
        .hold_cnt(hold_cnt),
        .timeout (timeout)
    );

    // Count value is only observed through timeout; kept on the port for debug probing.
    assign unused_hold_cnt = ^hold_cnt;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hang_err_d  = hang_err_q;
        if (take_branch) begin
            state_d     = StFlush;
            flush_cnt_d = FlushW'(FLUSH_CYCLES);
        end else if (!mem_busy) begin
            case (state_q)
                StRun: begin
                    if (rest_from_id) state_d = StHaz;
                end
                StHaz: begin
                    if (!rest_from_id) begin
                        state_d = StRun;
                    end else if (timeout) begin
                        state_d = StErr;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - 1'b1;
                    // Leave on the last bubble, but never while a redirect is still unaccepted.
                    if ((flush_cnt_d == '0) && (!redirect_valid_q || redirect_ready)) begin
                        state_d = StRun;
                    end
                end
                default: ;
            endcase
        end
        if (state_d == StErr) hang_err_d = 1'b1;
    end

    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (take_branch) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = branch_target;
        end else if (redirect_fire) begin
            redirect_valid_d = 1'b0;
        end
    end

    always_comb begin
        ctrl = CtrlRun;
        if (mem_busy || (state_q == StErr)) begin
            ctrl = CtrlOff;
        end else if (take_branch) begin
            ctrl = CtrlFlush;
        end else begin
            case (state_q)
                StRun, StHaz: begin
                    if (rest_from_id) ctrl = CtrlHold;
                end
                StFlush: ctrl = CtrlFlush;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StRun;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            hang_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            hang_err_q       <= hang_err_d;
        end
    end

    assign pc_en          = ctrl.pc_en;
    assign if_id_en       = ctrl.if_id_en;
    assign if_id_flush    = ctrl.if_id_flush;
    assign id_ex_flush    = ctrl.id_ex_flush;
    assign ex_mem_en      = ctrl.ex_mem_en;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign hang_err       = hang_err_q;

`ifdef PIPE_HOLD_PERF_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (hold_req && !take_branch && !mem_busy) stall_cycles_q <= stall_cycles_q + 1'b1;
            if (take_branch) flush_events_q <= flush_events_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed plus randomized bench for pipe_hold_ctrl against a cycle-level behavioural model.
module tb_pipe_hold_ctrl;
    localparam int unsigned PC_W         = 64;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned MAX_HOLD     = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rest_from_id, branch_flush, mem_busy, redirect_ready;
    logic [PC_W-1:0] branch_target;
    logic            pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en;
    logic            redirect_valid, hang_err;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipe_hold_ctrl #(
        .PC_W        (PC_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rest_from_id  (rest_from_id),
        .branch_flush  (branch_flush),
        .branch_target (branch_target),
        .mem_busy      (mem_busy),
        .redirect_ready(redirect_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_en     (ex_mem_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .hang_err      (hang_err),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "in a flush window", bubbles still owed, length of current hazard run, pending redirect.
    bit          m_err, m_flush, m_valid;
    int          m_bubbles, m_hold;
    logic [63:0] m_pc;
    logic [31:0] m_stall, m_flushes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_flush = 0; m_valid = 0; m_bubbles = 0; m_hold = 0;
        m_pc = '0; m_stall = '0; m_flushes = '0;
    endtask

    task automatic check_outputs(input string tag);
        logic [4:0] exp_ctrl;
        if (m_err || mem_busy)                exp_ctrl = 5'b00000;
        else if (branch_flush || m_flush)     exp_ctrl = 5'b01111;
        else if (rest_from_id)                exp_ctrl = 5'b00011;
        else                                  exp_ctrl = 5'b11001;
        check({tag, "/ctrl"}, 64'({pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en}),
              64'(exp_ctrl));
        check({tag, "/rv"}, 64'(redirect_valid), 64'(m_valid));
        check({tag, "/rpc"}, redirect_pc, m_pc);
        check({tag, "/hang"}, 64'(hang_err), 64'(m_err));
`ifdef PIPE_HOLD_PERF_EN
        check({tag, "/stall"}, 64'(stall_cycles), 64'(m_stall));
        check({tag, "/flushes"}, 64'(flush_events), 64'(m_flushes));
`else
        check({tag, "/stall"}, 64'(stall_cycles), 64'd0);
        check({tag, "/flushes"}, 64'(flush_events), 64'd0);
`endif
    endtask

    task automatic model_update();
        bit take, was_valid;
        take      = branch_flush && !m_err;
        was_valid = m_valid;
        if (take) begin
            m_valid = 1; m_pc = branch_target;
        end else if (m_valid && redirect_ready) begin
            m_valid = 0;
        end
        if (take) m_flushes++;
        if (!mem_busy && !take && !m_err && !m_flush && rest_from_id) m_stall++;
        if (take) begin
            m_flush = 1; m_bubbles = FLUSH_CYCLES; m_hold = 0;
        end else if (!mem_busy && !m_err) begin
            if (m_flush) begin
                if (m_bubbles > 0) m_bubbles--;
                if (m_bubbles == 0 && (!was_valid || redirect_ready)) m_flush = 0;
            end else if (rest_from_id) begin
                m_hold++;
                if (m_hold == MAX_HOLD) m_err = 1;
            end else begin
                m_hold = 0;
            end
        end
    endtask

    task automatic tick(input string tag, input bit rest, input bit br, input logic [63:0] tgt,
                        input bit busy, input bit rdy);
        @(negedge clk);
        rest_from_id = rest; branch_flush = br; branch_target = tgt;
        mem_busy = busy; redirect_ready = rdy;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        rest_from_id = 0; branch_flush = 0; mem_busy = 0; redirect_ready = 0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit r_rest;
        rst_n = 1'b0;
        rest_from_id = 0; branch_flush = 0; branch_target = '0; mem_busy = 0; redirect_ready = 0;
        model_reset();
        do_reset("reset");

        // Hazard for 3 cycles, then normal flow.
        for (int i = 0; i < 3; i++) tick("haz", 1, 0, '0, 0, 0);
        tick("haz_end", 0, 0, '0, 0, 0);
        tick("haz_idle", 0, 0, '0, 0, 0);
`ifdef PIPE_HOLD_PERF_EN
        check("stall3", 64'(stall_cycles), 64'd3);
`endif

        // Redirect accepted immediately; two bubble cycles.
        tick("redir", 0, 1, 64'h8000_0100, 0, 1);
        for (int i = 0; i < 3; i++) tick("redir_post", 0, 0, '0, 0, 1);

        // Backpressure with an overwriting second redirect.
        tick("bp_br1", 0, 1, 64'h8000_0100, 0, 0);
        for (int i = 0; i < 2; i++) tick("bp_wait", 0, 0, '0, 0, 0);
        tick("bp_br2", 0, 1, 64'h8000_0200, 0, 0);
        for (int i = 0; i < 4; i++) tick("bp_hold", 0, 0, '0, 0, 0);
        tick("bp_acc", 0, 0, '0, 0, 1);
        tick("bp_run", 0, 0, '0, 0, 0);

        // Branch beats hazard.
        tick("pri", 1, 1, 64'h8000_0300, 0, 1);
        for (int i = 0; i < 2; i++) tick("pri_flush", 1, 0, '0, 0, 1);
        tick("pri_haz", 1, 0, '0, 0, 1);
        tick("pri_run", 0, 0, '0, 0, 1);

        // Freeze during a flush window.
        tick("frz_br", 0, 1, 64'h8000_0400, 0, 1);
        for (int i = 0; i < 5; i++) tick("frz", 0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) tick("frz_post", 0, 0, '0, 0, 1);

        // Watchdog: unresolved hazard, sticky error, branch ignored, reset recovers.
        for (int i = 0; i < MAX_HOLD; i++) tick("wd", 1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) tick("wd_err", 0, 0, '0, 0, 0);
        tick("wd_br", 0, 1, 64'h8000_0500, 0, 1);
        do_reset("wd_reset");
        tick("wd_clear", 0, 0, '0, 0, 0);

        // Reset drops a pending redirect.
        tick("rst_br", 0, 1, 64'h8000_0600, 0, 0);
        tick("rst_pend", 0, 0, '0, 0, 0);
        do_reset("rst_mid");

        // Randomized traffic.
        r_rest = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset("rnd_reset");
            if ($urandom_range(0, 99) < 20) r_rest = !r_rest;
            tick("rnd", r_rest, $urandom_range(0, 99) < 10, {$urandom, $urandom},
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
